// File: rtl/game_state_controller.sv
// -----------------------------------------------------------------------------
// game_state_controller
//
// Top-level game FSM. Drives the 2-bit game state consumed by the enemy
// controller (0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER), scores enemy kills as a
// saturating 4-digit BCD value, and counts seconds spent in PLAY.
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset
//   start_btn     raw start button (asynchronous level)
//   pause_btn     raw pause button (asynchronous level)
//   enemy_enable  per-enemy alive flags; a 1->0 fall is a kill
//   enemy_v_flat  enemy i vertical position at [10*i+9:10*i]
//   state         game state
//   score         4-digit BCD score, digit 3 in [15:12]
//   play_sec      seconds spent in PLAY, binary, saturates at 255
//   high_score    best BCD score (tied to 0 unless HIGH_SCORE_EN)
//
// Build option: define HIGH_SCORE_EN to keep the best score across games.
// -----------------------------------------------------------------------------
module game_state_controller #(
    parameter int BOTTOM_V       = 380,
    parameter int TICKS_PER_SEC  = 25000000,
    parameter int SCORE_PER_KILL = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_btn,
    input  logic        pause_btn,
    input  logic [7:0]  enemy_enable,
    input  logic [79:0] enemy_v_flat,
    output logic [1:0]  state,
    output logic [15:0] score,
    output logic [7:0]  play_sec,
    output logic [15:0] high_score
);

    localparam int          TICK_W     = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [10:0] BOTTOM_V_L = 11'(BOTTOM_V);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [1:0]          start_sync_reg, pause_sync_reg;
    logic                start_prev_reg, pause_prev_reg;
    logic                start_rise, pause_rise;
    logic [7:0]          prev_enable_reg;
    logic [15:0]         score_reg;
    logic [7:0]          play_sec_reg;
    logic [TICK_W-1:0]   tick_reg;
    logic                in_play, game_start;

    // ---------------- button synchronisers and rising-edge detect ------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync_reg <= 2'b00;
            pause_sync_reg <= 2'b00;
            start_prev_reg <= 1'b0;
            pause_prev_reg <= 1'b0;
        end else begin
            start_sync_reg <= {start_sync_reg[0], start_btn};
            pause_sync_reg <= {pause_sync_reg[0], pause_btn};
            start_prev_reg <= start_sync_reg[1];
            pause_prev_reg <= pause_sync_reg[1];
        end
    end

    assign start_rise = start_sync_reg[1] & ~start_prev_reg;
    assign pause_rise = pause_sync_reg[1] & ~pause_prev_reg;

    // ---------------- breach: any alive enemy at/below the bottom line -------
    logic [7:0] breach_vec;
    logic       breach;

    for (genvar gi = 0; gi < 8; gi++) begin : g_breach
        assign breach_vec[gi] = enemy_enable[gi] &&
                                ({1'b0, enemy_v_flat[10*gi +: 10]} >= BOTTOM_V_L);
    end

    assign breach = |breach_vec;

    // ---------------- FSM: state register ------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= ST_IDLE;
        else        state_reg <= state_next;
    end

    // ---------------- FSM: next state ----------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            ST_IDLE:  if (start_rise) state_next = ST_PLAY;
            ST_PLAY: begin
                // Losing outranks pausing when both land in the same cycle.
                if (breach)          state_next = ST_OVER;
                else if (pause_rise) state_next = ST_PAUSE;
            end
            ST_PAUSE: if (pause_rise) state_next = ST_PLAY;
            ST_OVER:  if (start_rise) state_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs / decodes ---------------------------------
    always_comb begin
        state      = state_reg;
        in_play    = (state_reg == ST_PLAY);
        game_start = (state_reg == ST_IDLE) && start_rise;
    end

    // ---------------- kill count ---------------------------------------------
    logic [7:0] kill_vec;
    logic [3:0] kills;

    assign kill_vec = prev_enable_reg & ~enemy_enable;

    always_comb begin
        kills = 4'd0;
        for (int i = 0; i < 8; i++) kills = kills + 4'(kill_vec[i]);
    end

    // ---------------- BCD accumulate with saturation -------------------------
    // Points per cycle are at most 8*9 = 72, so the addend fits two BCD digits.
    logic [6:0]  add_val;
    logic [3:0]  add_digit [4];
    logic [4:0]  carry;
    logic [15:0] sum_digits;
    logic [15:0] score_added;

    assign add_val      = 7'(kills) * 7'(SCORE_PER_KILL);
    assign add_digit[0] = 4'(add_val % 7'd10);
    assign add_digit[1] = 4'(add_val / 7'd10);
    assign add_digit[2] = 4'd0;
    assign add_digit[3] = 4'd0;
    assign carry[0]     = 1'b0;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd
        logic [4:0] dsum;
        assign dsum          = {1'b0, score_reg[4*gi +: 4]} + {1'b0, add_digit[gi]}
                             + {4'b0000, carry[gi]};
        assign carry[gi+1]   = (dsum >= 5'd10);
        assign sum_digits[4*gi +: 4] = carry[gi+1] ? 4'(dsum - 5'd10) : dsum[3:0];
    end

    // A carry out of the thousands digit means the true sum passed 9999.
    assign score_added = carry[4] ? 16'h9999 : sum_digits;

    // ---------------- score / play-time datapath -----------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_enable_reg <= 8'h00;
            score_reg       <= 16'h0000;
            play_sec_reg    <= 8'h00;
            tick_reg        <= '0;
        end else begin
            prev_enable_reg <= enemy_enable;
            if (game_start) begin
                score_reg    <= 16'h0000;
                play_sec_reg <= 8'h00;
                tick_reg     <= '0;
            end else if (in_play) begin
                score_reg <= score_added;
                if (tick_reg == TICK_W'(TICKS_PER_SEC - 1)) begin
                    tick_reg <= '0;
                    if (play_sec_reg != 8'hFF) play_sec_reg <= play_sec_reg + 8'd1;
                end else begin
                    tick_reg <= tick_reg + TICK_W'(1);
                end
            end
        end
    end

    assign score    = score_reg;
    assign play_sec = play_sec_reg;

    // ---------------- optional high score ------------------------------------
`ifdef HIGH_SCORE_EN
    logic [15:0] high_score_reg;
    logic        game_over;

    assign game_over = in_play && breach;

    // BCD digits order the same way as binary, so a plain compare works.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                        high_score_reg <= 16'h0000;
        else if (game_over && (score_reg > high_score_reg)) high_score_reg <= score_reg;
    end

    assign high_score = high_score_reg;
`else
    assign high_score = 16'h0000;
`endif

endmodule

// File: tb/tb_game_state_controller.sv
module tb_game_state_controller;

    localparam int TPS    = 4;
    localparam int BOTTOM = 380;
    localparam int SPK    = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_btn, pause_btn;
    logic [7:0]  enemy_enable;
    logic [79:0] enemy_v_flat;
    logic [1:0]  state;
    logic [15:0] score;
    logic [7:0]  play_sec;
    logic [15:0] high_score;

    game_state_controller #(
        .BOTTOM_V      (BOTTOM),
        .TICKS_PER_SEC (TPS),
        .SCORE_PER_KILL(SPK)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_btn   (start_btn),
        .pause_btn   (pause_btn),
        .enemy_enable(enemy_enable),
        .enemy_v_flat(enemy_v_flat),
        .state       (state),
        .score       (score),
        .play_sec    (play_sec),
        .high_score  (high_score)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model (decimal arithmetic) -------------------
    int         m_state, m_score, m_sec, m_tick, m_high;
    logic [7:0] m_prev_en;
    logic [2:0] s_hist, p_hist;   // bit k = button level sampled k+1 edges ago

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [79:0] vflat_with(input int idx, input logic [9:0] val);
        logic [79:0] r;
        r = '0;
        r[10*idx +: 10] = val;
        return r;
    endfunction

    task automatic model_reset();
        m_state = 0; m_score = 0; m_sec = 0; m_tick = 0; m_high = 0;
        m_prev_en = 8'h00; s_hist = 3'b000; p_hist = 3'b000;
    endtask

    task automatic model_step(input logic s, input logic p, input logic [7:0] e,
                              input logic [79:0] v);
        bit breach, start_ev, pause_ev;
        int kills, old_score;
        breach = 0;
        kills  = 0;
        for (int i = 0; i < 8; i++) begin
            if (e[i] && (int'(v[10*i +: 10]) >= BOTTOM)) breach = 1;
            if (m_prev_en[i] && !e[i]) kills++;
        end
        // A press becomes an event two edges after it is first sampled.
        start_ev  = s_hist[1] && !s_hist[2];
        pause_ev  = p_hist[1] && !p_hist[2];
        old_score = m_score;
        case (m_state)
            0: if (start_ev) begin
                m_state = 1; m_score = 0; m_sec = 0; m_tick = 0;
            end
            1: begin
                m_score = (m_score + kills * SPK > 9999) ? 9999 : m_score + kills * SPK;
                m_tick++;
                if (m_tick == TPS) begin
                    m_tick = 0;
                    if (m_sec < 255) m_sec++;
                end
                if (breach) begin
`ifdef HIGH_SCORE_EN
                    if (old_score > m_high) m_high = old_score;
`endif
                    m_state = 3;
                end else if (pause_ev) begin
                    m_state = 2;
                end
            end
            2: if (pause_ev) m_state = 1;
            default: if (start_ev) m_state = 0;
        endcase
        m_prev_en = e;
        s_hist    = {s_hist[1:0], s};
        p_hist    = {p_hist[1:0], p};
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: drive inputs, advance model, compare every output after the edge.
    task automatic cycle(input logic s, input logic p, input logic [7:0] e, input logic [79:0] v);
        start_btn = s; pause_btn = p; enemy_enable = e; enemy_v_flat = v;
        model_step(s, p, e, v);
        @(posedge clk);
        #1;
        check("state", 32'(state), 32'(m_state));
        check("score", 32'(score), 32'(to_bcd(m_score)));
        check("play_sec", 32'(play_sec), 32'(m_sec));
        check("high_score", 32'(high_score), 32'(to_bcd(m_high)));
    endtask

    task automatic press_start(input logic [7:0] e);
        cycle(1'b1, 1'b0, e, '0);
        cycle(1'b0, 1'b0, e, '0);
        cycle(1'b0, 1'b0, e, '0);
    endtask

    // ---------------- directed vector table ----------------------------------
    typedef struct {
        logic        s;
        logic        p;
        logic [7:0]  en;
        logic [9:0]  v3;
        logic [1:0]  exp_state;
        logic [15:0] exp_score;
    } vec_t;

    vec_t tbl [28];

    logic [15:0] exp_high;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'hFF, 10'd0,   2'd0, 16'h0000};
        tbl[1]  = '{1'b1, 1'b0, 8'hFF, 10'd0,   2'd0, 16'h0000};
        tbl[2]  = '{1'b1, 1'b0, 8'hFF, 10'd0,   2'd1, 16'h0000};
        tbl[3]  = '{1'b1, 1'b0, 8'hFF, 10'd0,   2'd1, 16'h0000};
        tbl[4]  = '{1'b1, 1'b0, 8'hFF, 10'd0,   2'd1, 16'h0000};
        tbl[5]  = '{1'b0, 1'b0, 8'hF0, 10'd0,   2'd1, 16'h0004};
        tbl[6]  = '{1'b0, 1'b0, 8'hF0, 10'd0,   2'd1, 16'h0004};
        tbl[7]  = '{1'b0, 1'b0, 8'hF0, 10'd0,   2'd1, 16'h0004};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 10'd0,   2'd1, 16'h0008};
        tbl[9]  = '{1'b0, 1'b1, 8'h00, 10'd0,   2'd1, 16'h0008};
        tbl[10] = '{1'b0, 1'b1, 8'h00, 10'd0,   2'd1, 16'h0008};
        tbl[11] = '{1'b0, 1'b0, 8'hFF, 10'd0,   2'd2, 16'h0008};
        tbl[12] = '{1'b0, 1'b0, 8'h0F, 10'd0,   2'd2, 16'h0008};
        tbl[13] = '{1'b0, 1'b0, 8'h0F, 10'd0,   2'd2, 16'h0008};
        tbl[14] = '{1'b0, 1'b1, 8'hFF, 10'd0,   2'd2, 16'h0008};
        tbl[15] = '{1'b0, 1'b1, 8'hFF, 10'd0,   2'd2, 16'h0008};
        tbl[16] = '{1'b0, 1'b0, 8'hFF, 10'd0,   2'd1, 16'h0008};
        tbl[17] = '{1'b0, 1'b0, 8'hFF, 10'd379, 2'd1, 16'h0008};
        tbl[18] = '{1'b0, 1'b0, 8'hF7, 10'd380, 2'd1, 16'h0009};
        tbl[19] = '{1'b0, 1'b0, 8'hF7, 10'd380, 2'd1, 16'h0009};
        tbl[20] = '{1'b0, 1'b1, 8'hFF, 10'd379, 2'd1, 16'h0009};
        tbl[21] = '{1'b0, 1'b1, 8'hFF, 10'd379, 2'd1, 16'h0009};
        tbl[22] = '{1'b0, 1'b0, 8'hFF, 10'd380, 2'd3, 16'h0009};
        tbl[23] = '{1'b0, 1'b0, 8'h00, 10'd0,   2'd3, 16'h0009};
        tbl[24] = '{1'b1, 1'b0, 8'h00, 10'd0,   2'd3, 16'h0009};
        tbl[25] = '{1'b1, 1'b0, 8'h00, 10'd0,   2'd3, 16'h0009};
        tbl[26] = '{1'b0, 1'b0, 8'h00, 10'd0,   2'd0, 16'h0009};
        tbl[27] = '{1'b0, 1'b0, 8'h00, 10'd0,   2'd0, 16'h0009};

        // ---- reset ----
        rst_n = 1'b0; start_btn = 1'b0; pause_btn = 1'b0;
        enemy_enable = 8'h00; enemy_v_flat = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", 32'(state), 32'd0);
        check("reset_score", 32'(score), 32'h0);
        check("reset_play_sec", 32'(play_sec), 32'd0);
        check("reset_high", 32'(high_score), 32'h0);
        $display("reset: state=%0d score=%h play_sec=%0d high=%h", state, score, play_sec, high_score);
        rst_n = 1'b1;

        // ---- table: start latency, kills, pause masking, breach priority ----
        for (int r = 0; r < 28; r++) begin
            cycle(tbl[r].s, tbl[r].p, tbl[r].en, vflat_with(3, tbl[r].v3));
            check($sformatf("tbl%0d_state", r), 32'(state), 32'(tbl[r].exp_state));
            check($sformatf("tbl%0d_score", r), 32'(score), 32'(tbl[r].exp_score));
            $display("vec %0d: start=%b pause=%b en=%h v3=%0d -> state=%0d score=%h",
                     r, tbl[r].s, tbl[r].p, tbl[r].en, tbl[r].v3, state, score);
        end

        // ---- play-time counting across a pause (4 ticks per second) ----
        press_start(8'hFF);
        check("pt_enter_state", 32'(state), 32'd1);
        check("pt_enter_sec", 32'(play_sec), 32'd0);
        check("pt_enter_score", 32'(score), 32'h0);
        repeat (7) cycle(1'b0, 1'b0, 8'hFF, '0);
        cycle(1'b0, 1'b1, 8'hFF, '0);
        repeat (2) cycle(1'b0, 1'b0, 8'hFF, '0);
        check("pt_paused_state", 32'(state), 32'd2);
        check("pt_after10_sec", 32'(play_sec), 32'd2);
        repeat (17) cycle(1'b0, 1'b0, 8'hFF, '0);
        cycle(1'b0, 1'b1, 8'hFF, '0);
        repeat (2) cycle(1'b0, 1'b0, 8'hFF, '0);
        check("pt_resumed_state", 32'(state), 32'd1);
        check("pt_pause20_sec", 32'(play_sec), 32'd2);
        repeat (2) cycle(1'b0, 1'b0, 8'hFF, '0);
        check("pt_resume2_sec", 32'(play_sec), 32'd3);
        $display("play time: sec=%0d after pause and resume", play_sec);

        // ---- BCD carry and saturation ----
        repeat (99) begin
            cycle(1'b0, 1'b0, 8'hFE, '0);
            cycle(1'b0, 1'b0, 8'hFF, '0);
        end
        check("bcd_0099", 32'(score), 32'h0099);
        cycle(1'b0, 1'b0, 8'hFE, '0);
        cycle(1'b0, 1'b0, 8'hFF, '0);
        check("bcd_0100", 32'(score), 32'h0100);
        $display("bcd carry: score=%h", score);
        repeat (1237) begin
            cycle(1'b0, 1'b0, 8'h00, '0);
            cycle(1'b0, 1'b0, 8'hFF, '0);
        end
        cycle(1'b0, 1'b0, 8'hFC, '0);
        cycle(1'b0, 1'b0, 8'hFF, '0);
        check("bcd_9998", 32'(score), 32'h9998);
        cycle(1'b0, 1'b0, 8'h00, '0);
        check("bcd_sat_9999", 32'(score), 32'h9999);
        cycle(1'b0, 1'b0, 8'hFF, '0);
        cycle(1'b0, 1'b0, 8'h00, '0);
        check("bcd_sat_hold", 32'(score), 32'h9999);
        check("play_sec_sat", 32'(play_sec), 32'd255);
        $display("bcd saturation: score=%h play_sec=%0d", score, play_sec);

        // ---- asynchronous reset mid-game ----
        #2 rst_n = 1'b0;
        #1;
        check("areset_state", 32'(state), 32'd0);
        check("areset_score", 32'(score), 32'h0);
        check("areset_sec", 32'(play_sec), 32'd0);
        check("areset_high", 32'(high_score), 32'h0);
        $display("async reset: state=%0d score=%h", state, score);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // ---- high score across two games ----
`ifdef HIGH_SCORE_EN
        exp_high = 16'h0042;
`else
        exp_high = 16'h0000;
`endif
        press_start(8'hFF);
        repeat (5) begin
            cycle(1'b0, 1'b0, 8'h00, '0);
            cycle(1'b0, 1'b0, 8'hFF, '0);
        end
        cycle(1'b0, 1'b0, 8'hFC, '0);
        cycle(1'b0, 1'b0, 8'hFF, '0);
        cycle(1'b0, 1'b0, 8'hFF, vflat_with(3, 10'd380));
        check("g1_over", 32'(state), 32'd3);
        check("g1_score", 32'(score), 32'h0042);
        check("g1_high", 32'(high_score), 32'(exp_high));
        $display("game 1 over: score=%h high=%h", score, high_score);
        press_start(8'hFF);
        check("back_idle", 32'(state), 32'd0);
        press_start(8'hFF);
        check("g2_play", 32'(state), 32'd1);
        check("g2_score_clr", 32'(score), 32'h0);
        repeat (2) begin
            cycle(1'b0, 1'b0, 8'h00, '0);
            cycle(1'b0, 1'b0, 8'hFF, '0);
        end
        cycle(1'b0, 1'b0, 8'hFE, '0);
        cycle(1'b0, 1'b0, 8'hFF, '0);
        cycle(1'b0, 1'b0, 8'hFF, vflat_with(3, 10'd380));
        check("g2_over", 32'(state), 32'd3);
        check("g2_score", 32'(score), 32'h0017);
        check("g2_high", 32'(high_score), 32'(exp_high));
        $display("game 2 over: score=%h high=%h", score, high_score);

        // ---- randomized play against the model ----
        begin
            logic       rs, rp;
            logic [7:0] re;
            logic [79:0] rv;
            rs = 1'b0; rp = 1'b0; re = 8'hFF;
            for (int c = 0; c < 4000; c++) begin
                if ($urandom_range(0, 19) == 0) rs = ~rs;
                if ($urandom_range(0, 19) == 0) rp = ~rp;
                if ($urandom_range(0, 1) == 0) re = 8'($urandom);
                rv = '0;
                for (int i = 0; i < 8; i++) rv[10*i +: 10] = 10'($urandom_range(0, 370));
                if ($urandom_range(0, 99) == 0)
                    rv[10*$urandom_range(0, 7) +: 10] = 10'($urandom_range(375, 420));
                cycle(rs, rp, re, rv);
            end
            $display("random: %0d cycles done, state=%0d score=%h", 4000, state, score);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_state_controller.md
Name: game_state_controller

Overview:
Top-level game FSM that drives the 2-bit `state` bus consumed by the enemy controller: 0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER. It consumes the enemy controller's outputs:
- `enemy_enable` falling edges count as kills and feed a BCD score.
- Any enabled enemy's vertical position reaching the bottom line ends the game.
It also keeps a play-time seconds counter for the HUD.

Parameters:
BOTTOM_V, 380, enemy vertical position at or beyond which the player loses.
TICKS_PER_SEC, 25000000, clk cycles per play-time second.
SCORE_PER_KILL, 1, BCD points per kill (1..9).

Ports:
clk  input  1  system clock (all logic on rising edge).
rst_n  input  1  asynchronous active-low reset.
start_btn  input  1  raw start button, asynchronous level.
pause_btn  input  1  raw pause button, asynchronous level.
enemy_enable  input  8  per-enemy alive flags from the enemy controller.
enemy_v_flat  input  80  enemy i vertical position at bits [10*i+9:10*i].
state  output  2  game state.
score  output  16  4-digit BCD score, digit 3 in [15:12].
play_sec  output  8  seconds spent in PLAY, binary.
high_score  output  16  best BCD score (see Optional Feature).

Behaviour:
- Reset (rst_n low, async):
  - state=0, score=0, play_sec=0, high_score=0.
  - Synchronisers, edge registers, prev_enable and tick counter all 0.
- Buttons:
  - Each button passes through a 2-flop synchroniser, then an edge register.
  - start_rise = sync2 & ~prev; pause_rise likewise.
  - Latency: input high before edge k gives a state change at edge k+2. Holding a button produces exactly one event.
- breach: combinational. True when any i has enemy_enable[i]=1 and enemy_v[i] >= BOTTOM_V.
- FSM transitions:
  - IDLE: start_rise -> PLAY. On that edge, score, play_sec and tick counter clear to 0.
  - PLAY: breach -> OVER. Else pause_rise -> PAUSE. Breach has priority over pause in the same cycle.
  - PAUSE: pause_rise -> PLAY. start_rise is ignored. Breach is not evaluated.
  - OVER: start_rise -> IDLE. All counters hold.
  - pause_rise in IDLE or OVER is ignored. Any state holds otherwise.
- Kill detection:
  - prev_enable is registered every cycle.
  - kills = popcount(prev_enable & ~enemy_enable), range 0..8.
  - Counted only when the registered state is PLAY. Falls seen in IDLE, PAUSE or OVER are ignored.
- Score:
  - Adds kills*SCORE_PER_KILL per cycle as a BCD add, with per-digit decimal carry.
  - Saturates at 9999: if the true sum exceeds 9999, score=16'h9999.
  - If breach and kills occur in the same cycle, the kills are still scored.
- Play time:
  - Tick counter counts only in PLAY and holds in PAUSE.
  - At TICKS_PER_SEC-1 the counter wraps to 0 and play_sec increments.
  - play_sec saturates at 255.
- Reset mid-game returns to IDLE immediately with all outputs 0.

Optional Feature:
Macro HIGH_SCORE_EN.
- Defined:
  - On the PLAY->OVER edge, if score > high_score (BCD compare, equal to binary compare), high_score <= score.
  - high_score survives OVER->IDLE->PLAY; it is cleared only by rst_n.
- Undefined: high_score is tied to 16'h0000 and no compare logic is built.

Test Plan:
- Reset then start: rst_n low 3 cycles, then release. Pulse start_btn high 5 cycles -> state 0->1 exactly 2 edges after first sampled high, one transition only. score=0000, play_sec=0.
- Kills in PLAY: enemy_enable 8'hFF -> 8'hF0 in one cycle, then 8'hF0 -> 8'h00 three cycles later, SCORE_PER_KILL=1 -> score 0004 then 0008. Same fall in PAUSE -> no change.
- BCD carry and saturation: score preloaded to 0099 via 99 single kills, one more kill -> 0100. Drive to 9998, then 8-enemy simultaneous fall -> 9999, held.
- Breach priority: enemy 3 enabled, enemy_v[3]=380, pause_rise in the same cycle -> state 3 (OVER), not 2. enemy_v[3]=379 -> stays PLAY. Enemy disabled at 380 -> no breach.
- Pause timing with TICKS_PER_SEC=4: 10 cycles in PLAY -> play_sec=2. Pause 20 cycles -> still 2. Resume 2 cycles -> 3.
- HIGH_SCORE_EN defined: game 1 ends with 0042 -> high_score 0042. Game 2 ends with 0017 -> stays 0042. Undefined -> high_score always 0000.
